// File: rtl/mem_wb_stage.sv
// MEM stage with word-addressed data memory plus the MEM/WB pipeline register.
// Latency: ReadDataM/AlignErrM combinational; W outputs one cycle after M inputs.
// Backpressure: StallW holds W and blocks the store; FlushW bubbles W and blocks the store.
module mem_wb_stage #(
  parameter int ADDR_W = 6,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ALUOutM,
  input  logic [31:0]      WriteDataM,
  input  logic [4:0]       WriteRegM,
  input  logic             RegWriteM,
  input  logic             MemtoRegM,
  input  logic             MemWriteM,
  input  logic             StallW,
  input  logic             FlushW,
  output logic [31:0]      ReadDataM,
  output logic             AlignErrM,
  output logic [31:0]      ReadDataW,
  output logic [31:0]      ALUOutW,
  output logic [4:0]       WriteRegW,
  output logic             RegWriteW,
  output logic             MemtoRegW,
  output logic [31:0]      ResultW,
  output logic [ERR_W-1:0] ErrCount
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] memIdx;
  logic              storeEn;
  logic              normalUpd;

  // Byte address to word index; upper address bits are ignored so accesses wrap.
  assign memIdx    = ALUOutM[ADDR_W+1:2];
  assign AlignErrM = (MemWriteM | MemtoRegM) & (ALUOutM[1:0] != 2'b00);
  assign ReadDataM = mem[memIdx];

  // A store only commits when the instruction actually advances into W.
  assign normalUpd = ~FlushW & ~StallW;
  assign storeEn   = MemWriteM & ~AlignErrM & normalUpd & ~rst;

  // Data memory write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (storeEn) begin
      mem[memIdx] <= WriteDataM;
    end
  end

  // MEM/WB register: flush beats stall beats normal advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ReadDataW <= '0;
      ALUOutW   <= '0;
      WriteRegW <= '0;
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
    end else if (FlushW) begin
      ReadDataW <= '0;
      ALUOutW   <= '0;
      WriteRegW <= '0;
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
    end else if (!StallW) begin
      ReadDataW <= ReadDataM;
      ALUOutW   <= ALUOutM;
      WriteRegW <= WriteRegM;
      // A misaligned access must never reach the register file.
      RegWriteW <= RegWriteM & ~AlignErrM;
      MemtoRegW <= MemtoRegM;
    end
  end

  // Saturating count of misaligned accesses that actually advanced into W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ErrCount <= '0;
    end else if (normalUpd && AlignErrM && (ErrCount != ERR_MAX)) begin
      ErrCount <= ErrCount + ERR_W'(1);
    end
  end

  assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage with a behavioural model of memory and the W register.
// Latency: model advances on each stepped clock edge; outputs compared every negedge.
// Backpressure: stall/flush randomized and exercised directly.
module tb_mem_wb_stage;

  localparam int ADDR_W = 6;
  localparam int ERR_W  = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      ALUOutM = '0;
  logic [31:0]      WriteDataM = '0;
  logic [4:0]       WriteRegM = '0;
  logic             RegWriteM = 1'b0;
  logic             MemtoRegM = 1'b0;
  logic             MemWriteM = 1'b0;
  logic             StallW = 1'b0;
  logic             FlushW = 1'b0;
  logic [31:0]      ReadDataM;
  logic             AlignErrM;
  logic [31:0]      ReadDataW;
  logic [31:0]      ALUOutW;
  logic [4:0]       WriteRegW;
  logic             RegWriteW;
  logic             MemtoRegW;
  logic [31:0]      ResultW;
  logic [ERR_W-1:0] ErrCount;

  mem_wb_stage #(.ADDR_W(ADDR_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .MemWriteM(MemWriteM), .StallW(StallW), .FlushW(FlushW),
    .ReadDataM(ReadDataM), .AlignErrM(AlignErrM), .ReadDataW(ReadDataW),
    .ALUOutW(ALUOutW), .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .MemtoRegW(MemtoRegW), .ResultW(ResultW), .ErrCount(ErrCount)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] mMem [DEPTH];
  logic [31:0] mRd, mAlu;
  logic [4:0]  mWr;
  logic        mRw, mM2r;
  int          mErr;

  int  nTests = 0;
  int  nFail  = 0;
  bit  cmpEn  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setIn(input logic [31:0] a, input logic [31:0] wd, input logic [4:0] wr,
                       input logic rw, input logic m2r, input logic mw,
                       input logic st, input logic fl);
    ALUOutM = a; WriteDataM = wd; WriteRegM = wr; RegWriteM = rw;
    MemtoRegM = m2r; MemWriteM = mw; StallW = st; FlushW = fl;
  endtask

  task automatic modelClear();
    mRd = '0; mAlu = '0; mWr = '0; mRw = 1'b0; mM2r = 1'b0; mErr = 0;
  endtask

  // One clock edge: the model applies the architectural rules to the current inputs.
  task automatic step();
    int          i;
    logic        mis;
    logic [31:0] rd;
    i   = int'(ALUOutM / 4) % DEPTH;
    mis = (MemWriteM || MemtoRegM) && (ALUOutM % 4 != 0);
    rd  = mMem[i];
    @(posedge clk);
    if (rst) begin
      modelClear();
    end else if (FlushW) begin
      mRd = '0; mAlu = '0; mWr = '0; mRw = 1'b0; mM2r = 1'b0;
    end else if (!StallW) begin
      mRd = rd; mAlu = ALUOutM; mWr = WriteRegM; mRw = RegWriteM && !mis; mM2r = MemtoRegM;
      if (mis && mErr < 255) mErr++;
      if (MemWriteM && !mis) mMem[i] = WriteDataM;
    end
    #1;
  endtask

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmpEn) begin
        chk("ReadDataM", ReadDataM, mMem[int'(ALUOutM / 4) % DEPTH]);
        chk("AlignErrM", 32'(AlignErrM), 32'((MemWriteM || MemtoRegM) && (ALUOutM % 4 != 0)));
        chk("ReadDataW", ReadDataW, mRd);
        chk("ALUOutW",   ALUOutW, mAlu);
        chk("WriteRegW", 32'(WriteRegW), 32'(mWr));
        chk("RegWriteW", 32'(RegWriteW), 32'(mRw));
        chk("MemtoRegW", 32'(MemtoRegW), 32'(mM2r));
        chk("ResultW",   ResultW, mM2r ? mRd : mAlu);
        chk("ErrCount",  32'(ErrCount), 32'(mErr));
      end
    end
  end

  initial begin
    logic [31:0] a;
    modelClear();
    step();
    step();
    chk("reset_ResultW", ResultW, 32'h0);
    chk("reset_ErrCount", 32'(ErrCount), 32'h0);
    chk("reset_RegWriteW", 32'(RegWriteW), 32'h0);
    rst = 1'b0;

    // Give every word a known value, then flush out X read data.
    for (int i = 0; i < DEPTH; i++) begin
      setIn(32'(i * 4), $urandom, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
    end
    setIn(32'h0, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    cmpEn = 1'b1;

    // Store then load back.
    setIn(32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); step();
    setIn(32'h10, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    chk("load_ReadDataM", ReadDataM, 32'hDEADBEEF);
    step();
    chk("load_ReadDataW", ReadDataW, 32'hDEADBEEF);
    chk("load_ResultW", ResultW, 32'hDEADBEEF);

    // Read-during-write to the same word shows the old contents.
    setIn(32'h20, 32'h11111111, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); step();
    setIn(32'h20, 32'h22222222, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); #1;
    chk("rdw_old", ReadDataM, 32'h11111111);
    step();
    chk("rdw_ReadDataW", ReadDataW, 32'h11111111);
    setIn(32'h20, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    chk("rdw_new", ReadDataM, 32'h22222222);
    step();

    // Stalled store is suppressed and W holds.
    setIn(32'h04, 32'h0BADF00D, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); step();
    setIn(32'h04, 32'h12345678, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); step();
    chk("stall_hold_ALUOutW", ALUOutW, 32'h4);
    chk("stall_hold_RegWriteW", 32'(RegWriteW), 32'h0);
    setIn(32'h04, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    chk("stall_no_store", ReadDataM, 32'h0BADF00D);
    step();
    setIn(32'h04, 32'h12345678, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); step();
    setIn(32'h04, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    chk("unstalled_store", ReadDataM, 32'h12345678);
    step();

    // Flush beats stall.
    setIn(32'h10, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1); step();
    chk("flush_RegWriteW", 32'(RegWriteW), 32'h0);
    chk("flush_ALUOutW", ALUOutW, 32'h0);
    chk("flush_ResultW", ResultW, 32'h0);
    chk("flush_ErrCount", 32'(ErrCount), 32'h0);

    // Misaligned load.
    setIn(32'h13, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    chk("mis_AlignErrM", 32'(AlignErrM), 32'h1);
    step();
    chk("mis_RegWriteW", 32'(RegWriteW), 32'h0);
    chk("mis_ErrCount", 32'(ErrCount), 32'h1);

    // Address wrap.
    setIn(32'h100, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); step();
    setIn(32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    chk("wrap_mem0", ReadDataM, 32'hCAFEF00D);
    step();

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      setIn(a, $urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom),
            1'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
      step();
    end

    // Saturation.
    setIn(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; modelClear(); step(); rst = 1'b0;
    for (int n = 0; n < 300; n++) begin
      setIn(32'h13 + 32'(n * 4), 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
    end
    chk("sat_ErrCount", 32'(ErrCount), 32'd255);

    // Reset asserted mid-cycle during a store.
    setIn(32'h08, 32'h77777777, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    rst = 1'b1; modelClear();
    #1;
    chk("midrst_ALUOutW", ALUOutW, 32'h0);
    chk("midrst_ResultW", ResultW, 32'h0);
    chk("midrst_ErrCount", 32'(ErrCount), 32'h0);
    step();
    rst = 1'b0;
    setIn(32'h08, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("midrst_no_store", 32'(ReadDataM == 32'h77777777), 32'(mMem[2] == 32'h77777777));
    step();
    step();

    cmpEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
